pending_bit_encoder: RTL and testbench
======================================

// Module: pending_bit_encoder
// PURPOSE
//  Inverse of the 5-to-32 register-select decoder. Captures a 32-bit request
//  vector (e.g. pending exception/interrupt lines or a register-dirty mask).
//  Emits the 5-bit index of each set bit, lowest index first, one per
//  valid/ready handshake. Sits between cause/status collection logic and the
//  control unit, which consumes encoded indices serially.
// PARAMETERS
//  WIDTH   32  number of request lines; must equal 2**IDX_W
//  IDX_W   5   width of encoded index output
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  load       in   1        capture req_vec this cycle (honoured only when busy=0)
//  req_vec    in   WIDTH    request vector; bit i set = line i pending
//  ready      in   1        consumer accepts current idx this cycle
//  valid      out  1        idx/onehot hold a pending request
//  idx        out  IDX_W    index of lowest set pending bit
//  onehot     out  WIDTH    decoded form of idx (pend & -pend); 0 when valid=0
//  remaining  out  IDX_W+1  popcount of pending register (0..32)
//  busy       out  1        scan in progress; load is ignored
//  done       out  1        one-cycle pulse: vector fully drained, or zero vector loaded
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, pend=0, done=0.
//    valid, busy, idx, onehot and remaining are all 0.
//  - State held in a register: IDLE or SCAN. pend[WIDTH-1:0] is a register.
//    valid, idx, onehot and remaining are derived only from pend and state.
//    There is no combinational path from any input to any output.
//  - IDLE: valid=0, busy=0.
//    - load=1, req_vec!=0: pend<=req_vec, go to SCAN. valid=1 the next cycle
//      (1-cycle latency).
//    - load=1, req_vec==0: stay in IDLE; done=1 the next cycle.
//  - SCAN: valid=1, busy=1, idx=position of lowest set bit of pend, onehot=1<<idx.
//    - Handshake at a rising edge with valid=1 and ready=1:
//      - pend[idx] cleared.
//      - If that was the last set bit: go to IDLE, done=1 for exactly the
//        next cycle.
//      - Otherwise the next idx appears the following cycle. This gives
//        back-to-back grants, one per cycle, while ready stays 1.
//    - ready=0: idx, onehot, remaining and pend all hold stable.
//  - load during SCAN is ignored entirely; pend is not modified.
//    A load in the same cycle as the final handshake is also ignored. The
//    block accepts a new vector only from IDLE, so the earliest load after
//    the last handshake is one cycle later.
//  - done is a registered single-cycle pulse; it is 0 in every other cycle.
//  - remaining = popcount(pend). It decrements by exactly 1 per handshake and
//    reads 32 after loading all-ones.
//  - Order is strictly ascending index. Bits of req_vec that change after
//    capture have no effect.
//  - Reset asserted mid-SCAN: pend is discarded immediately; no done pulse.
// TESTING
//  1. Load 0x0000_0001, ready=1 -> next cycle valid=1, idx=0,
//     onehot=0x0000_0001, remaining=1; following cycle done=1, busy=0.
//  2. Load 0x8000_0011, ready=1 -> idx sequence 0,4,31 on consecutive cycles;
//     remaining 3,2,1; done pulses once after idx 31.
//  3. Load 0x0000_0300, ready=0 for 5 cycles -> idx=8 and remaining=2 held;
//     then ready=1 -> idx 8 then 9, then done.
//  4. Load 0x0000_000F; mid-scan, load=1 with req_vec=0xFFFF_0000 -> ignored;
//     only idx 0..3 are emitted.
//  5. Load 0x0000_0000 -> valid never asserts; done=1 one cycle later; busy stays 0.
//  6. Load 0xFFFF_FFFF, ready=1 -> idx 0..31 in 32 consecutive cycles.
//     In a second run, drop rst_n after idx=10 -> all outputs 0 at once;
//     no done; the next load behaves normally.

Source files
------------

// File: rtl/pending_bit_encoder.sv
// Serialises a captured request vector into ascending set-bit indices,
// one per valid/ready handshake.
module pending_bit_encoder #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] req_vec,
   input  logic             ready,
   output logic             valid,
   output logic [IDX_W-1:0] idx,
   output logic [WIDTH-1:0] onehot,
   output logic [IDX_W:0]   remaining,
   output logic             busy,
   output logic             done
);

   typedef enum logic {
      IDLE,
      SCAN
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] pend_q;
   logic             done_q;

   logic [WIDTH-1:0] low_c;
   logic [WIDTH-1:0] pend_d;
   logic [IDX_W-1:0] idx_c;
   logic [IDX_W:0]   cnt_c;

   // Isolate the lowest set bit: pend & -pend.
   assign low_c  = pend_q & (~pend_q + WIDTH'(1));
   assign pend_d = pend_q & ~low_c;

   always_comb begin
      idx_c = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (pend_q[i]) idx_c = IDX_W'(i);
      end
   end

   always_comb begin
      cnt_c = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_c = cnt_c + {{IDX_W{1'b0}}, pend_q[i]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (load) begin
                  if (req_vec != '0) begin
                     pend_q  <= req_vec;
                     state_q <= SCAN;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (ready) begin
                  pend_q <= pend_d;
                  if (pend_d == '0) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign valid     = (state_q == SCAN);
   assign busy      = (state_q == SCAN);
   assign idx       = valid ? idx_c : '0;
   assign onehot    = valid ? low_c : '0;
   assign remaining = cnt_c;
   assign done      = done_q;

endmodule

// File: tb/tb_pending_bit_encoder.sv
// Scoreboard bench: expected grants queued at load, popped on handshakes.
module tb_pending_bit_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [31:0] req_vec = '0;
   logic        ready = 1'b0;
   logic        valid;
   logic [4:0]  idx;
   logic [31:0] onehot;
   logic [5:0]  remaining;
   logic        busy;
   logic        done;

   typedef struct {
      int idx;
      int rem;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc;

   pending_bit_encoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .req_vec   (req_vec),
      .ready     (ready),
      .valid     (valid),
      .idx       (idx),
      .onehot    (onehot),
      .remaining (remaining),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n && valid && ready) begin
         if (sb.size() == 0) begin
            chk("sb_extra_grant", sb.size(), 1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("idx", 32'(idx), e.idx);
            chk("onehot", onehot, 32'd1 << e.idx);
            chk("remaining", 32'(remaining), e.rem);
            chk("busy", 32'(busy), 1);
         end
      end
   end

   task automatic push_vec(input logic [31:0] v);
      int n;
      n = $countones(v);
      for (int i = 0; i < 32; i++) begin
         if (v[i]) begin
            sb.push_back('{idx: i, rem: n});
            n--;
         end
      end
   endtask

   task automatic do_load(input logic [31:0] v);
      @(posedge clk);
      #1;
      load    = 1'b1;
      req_vec = v;
      push_vec(v);
      @(posedge clk);
      #1;
      load = 1'b0;
   endtask

   task automatic wait_drain(input string tag, output int c);
      c = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (done) begin
            c = i;
            break;
         end
      end
      if (c == 0) chk({tag, "_timeout"}, 0, 1);
      chk({tag, "_sb_empty"}, sb.size(), 0);
      chk({tag, "_busy_at_done"}, 32'(busy), 0);
      @(negedge clk);
      chk({tag, "_done_1cyc"}, 32'(done), 0);
      chk({tag, "_valid_idle"}, 32'(valid), 0);
   endtask

   initial begin
      #2;
      chk("rst_valid", 32'(valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_idx", 32'(idx), 0);
      chk("rst_onehot", onehot, 0);
      chk("rst_remaining", 32'(remaining), 0);
      chk("rst_done", 32'(done), 0);
      #20;
      rst_n = 1'b1;

      // 1: single bit
      ready = 1'b1;
      do_load(32'h0000_0001);
      wait_drain("t1", cyc);
      chk("t1_latency", cyc, 2);

      // 2: sparse, back-to-back
      do_load(32'h8000_0011);
      wait_drain("t2", cyc);
      chk("t2_latency", cyc, 4);

      // 3: stall holds outputs
      ready = 1'b0;
      do_load(32'h0000_0300);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_hold_valid", 32'(valid), 1);
         chk("t3_hold_idx", 32'(idx), 8);
         chk("t3_hold_rem", 32'(remaining), 2);
      end
      @(posedge clk);
      #1;
      ready = 1'b1;
      wait_drain("t3", cyc);

      // 4: load during scan ignored
      do_load(32'h0000_000F);
      @(posedge clk);
      #1;
      load    = 1'b1;
      req_vec = 32'hFFFF_0000;
      @(posedge clk);
      #1;
      load = 1'b0;
      wait_drain("t4", cyc);
      chk("t4_rem_after", 32'(remaining), 0);

      // 5: zero vector
      do_load(32'h0000_0000);
      @(negedge clk);
      chk("t5_valid", 32'(valid), 0);
      chk("t5_busy", 32'(busy), 0);
      chk("t5_done", 32'(done), 1);
      @(negedge clk);
      chk("t5_done_drop", 32'(done), 0);
      chk("t5_valid2", 32'(valid), 0);

      // 6a: full vector, 32 consecutive grants
      do_load(32'hFFFF_FFFF);
      wait_drain("t6a", cyc);
      chk("t6a_latency", cyc, 33);

      // 6b: reset mid-scan after idx 10 accepted
      do_load(32'hFFFF_FFFF);
      repeat (11) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6b_valid", 32'(valid), 0);
      chk("t6b_busy", 32'(busy), 0);
      chk("t6b_idx", 32'(idx), 0);
      chk("t6b_onehot", onehot, 0);
      chk("t6b_rem", 32'(remaining), 0);
      chk("t6b_sb_left", sb.size(), 21);
      sb.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6b_no_done", 32'(done), 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6b_no_done_rel", 32'(done), 0);
      do_load(32'h0000_0005);
      wait_drain("t6c", cyc);
      chk("t6c_latency", cyc, 3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
